// File: rtl/edge_detector_if.sv
// Command-side bundle of edge_detector: raw level/enable/clear in, filtered level,
// edge pulses and event count out.
interface edge_detector_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   i_in;
  logic                   i_en;
  logic                   i_clr;
  logic                   o_level;
  logic                   o_posedge;
  logic                   o_negedge;
  logic                   o_edge;
  logic [COUNT_WIDTH-1:0] o_count;

  modport master (
    output i_in, i_en, i_clr,
    input  o_level, o_posedge, o_negedge, o_edge, o_count
  );

  modport slave (
    input  i_in, i_en, i_clr,
    output o_level, o_posedge, o_negedge, o_edge, o_count
  );
endinterface

// File: rtl/edge_detector.sv
// Synchronizes and debounces an asynchronous level, emitting registered one-cycle
// rise/fall/any-edge pulses and a wrapping count of accepted edges.
module edge_detector #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  edge_detector_if.slave bus
);

  localparam int                FILT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [FILT_W-1:0]      r_filt;
  logic                   r_level;
  logic                   r_posedge;
  logic                   r_negedge;
  logic                   r_edge;
  logic [COUNT_WIDTH-1:0] r_count;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Metastability chain; runs independently of the enable.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_in};
    end
  end

  // Debounce: a differing level must persist FILTER_CYCLES cycles before it toggles r_level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_filt    <= '0;
      r_level   <= 1'b0;
      r_posedge <= 1'b0;
      r_negedge <= 1'b0;
      r_edge    <= 1'b0;
    end else if (!bus.i_en) begin
      r_filt    <= '0;
      r_level   <= r_level;
      r_posedge <= 1'b0;
      r_negedge <= 1'b0;
      r_edge    <= 1'b0;
    end else if (w_sync == r_level) begin
      r_filt    <= '0;
      r_level   <= r_level;
      r_posedge <= 1'b0;
      r_negedge <= 1'b0;
      r_edge    <= 1'b0;
    end else if (r_filt < FILT_LAST) begin
      r_filt    <= r_filt + FILT_W'(1);
      r_level   <= r_level;
      r_posedge <= 1'b0;
      r_negedge <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_filt    <= '0;
      r_level   <= ~r_level;
      r_posedge <= ~r_level;
      r_negedge <= r_level;
      r_edge    <= 1'b1;
    end
  end

  // Event counter follows the registered pulse, so it lags o_edge by one cycle; clear wins.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (bus.i_clr) begin
      r_count <= '0;
    end else if (r_edge) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign bus.o_level   = r_level;
  assign bus.o_posedge = r_posedge;
  assign bus.o_negedge = r_negedge;
  assign bus.o_edge    = r_edge;
  assign bus.o_count   = r_count;

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: vector table plus multi-cycle corner sequences.
module tb_edge_detector;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  edge_detector_if #(.COUNT_WIDTH(CW)) bus ();

  edge_detector #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .COUNT_WIDTH  (CW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {level, posedge, negedge, edge, count[3:0]}
  logic [7:0] w_outs;
  assign w_outs = {bus.o_level, bus.o_posedge, bus.o_negedge, bus.o_edge, bus.o_count};

  typedef struct packed {
    logic       in;
    logic       en;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [27];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic toggle_and_wait(output int lat);
    bus.i_in = ~bus.i_in;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (bus.o_edge) break;
    end
    chk("edge_dir", 8'({bus.o_posedge, bus.o_negedge}), 8'({bus.i_in, ~bus.i_in}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int hold;
    int pulses;

    // in, en, clr, expected {level,pos,neg,edge,count}
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h81};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h81};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h81};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h81};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h81};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h31};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h02};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h02};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 8'hD2};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h83};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h83};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 8'h83};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 8'h33};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 8'h04};
    tbl[25] = '{1'b1, 1'b0, 1'b0, 8'h04};
    tbl[26] = '{1'b1, 1'b0, 1'b1, 8'h00};

    bus.i_in  = 1'b1;
    bus.i_en  = 1'b1;
    bus.i_clr = 1'b0;
    rst_n     = 1'b0;

    // Reset held with input high, then the intended post-reset posedge.
    repeat (3) tick();
    chk("reset_hold", w_outs, 8'h00);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("post_reset_%0d", k), w_outs,
          (k == 6) ? 8'hD0 : ((k == 7) ? 8'h81 : 8'h00));
    end

    // Fall, 3-cycle glitch, 4-cycle pulse, enable freeze and clear.
    for (int i = 0; i < 27; i++) begin
      bus.i_in  = tbl[i].in;
      bus.i_en  = tbl[i].en;
      bus.i_clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i), w_outs, tbl[i].exp);
    end
    bus.i_clr = 1'b0;

    // Enable freeze for 20 cycles, then re-enable with input still high.
    bus.i_en = 1'b0;
    bus.i_in = 1'b1;
    repeat (20) begin
      tick();
      chk("freeze", w_outs, 8'h00);
    end
    bus.i_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("reenable_%0d", k), w_outs, (k == 4) ? 8'hD0 : 8'h00);
    end
    tick();
    chk("reenable_cnt", w_outs, 8'h81);

    // Counter wrap over 17 edges, then clear colliding with the 18th edge.
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    chk("clr", w_outs, 8'h80);
    for (int e = 1; e <= 17; e++) begin
      toggle_and_wait(lat);
      chk("latency", 8'(lat), 8'd6);
      tick();
      tick();
      chk("count", 8'(bus.o_count), 8'(e % 16));
    end
    chk("wrap", 8'(bus.o_count), 8'd1);
    toggle_and_wait(lat);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    chk("clr_vs_edge", 8'(bus.o_count), 8'd0);
    tick();
    chk("clr_vs_edge_hold", 8'(bus.o_count), 8'd0);

    // Async reset mid-filter with count 5.
    for (int e = 1; e <= 5; e++) begin
      toggle_and_wait(lat);
      tick();
      tick();
    end
    bus.i_in = 1'b1;
    repeat (4) tick();
    chk("pre_reset", w_outs, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clr", w_outs, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("after_async_%0d", k), w_outs,
          (k == 6) ? 8'hD0 : ((k == 7) ? 8'h81 : 8'h00));
    end

    // Random-length level segments, one accepted edge per segment.
    for (int s = 0; s < 12; s++) begin
      bus.i_in = ~bus.i_in;
      hold     = int'($urandom_range(16, 8));
      pulses   = 0;
      for (int c = 0; c < hold; c++) begin
        tick();
        chk("edge_or", 8'(bus.o_edge), 8'(bus.o_posedge | bus.o_negedge));
        chk("pos_neg_excl", 8'(bus.o_posedge & bus.o_negedge), 8'd0);
        if (bus.o_edge) begin
          pulses++;
          chk("alternate", 8'(bus.o_posedge), 8'(bus.i_in));
        end
      end
      chk("one_pulse_per_level", 8'(pulses), 8'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
